reservation_station: RTL and testbench

//  Holds decoded ops dispatched by the reorder buffer until both source operands
//  are available, then issues them one per cycle to the ALU. Sits between ROB

---
 rtl/reservation_station.sv | 172 +++++++++++++++++
 tb/tb_reservation_station.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ops until both operands are captured,
// snooping the ALU/memory result buses, and issues one ready op per cycle to the ALU.
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      in_value1,
  input  logic [TAG_W-1:0] in_query1,
  input  logic [31:0]      in_value2,
  input  logic [TAG_W-1:0] in_query2,
  input  logic [TAG_W-1:0] alu_num,
  input  logic [31:0]      alu_value,
  input  logic [TAG_W-1:0] mem_num,
  input  logic [31:0]      mem_value,
  input  logic             alu_stall,
  input  logic             flush,
  output logic             rs_full,
  output logic             issue_valid,
  output logic [OP_W-1:0]  issue_op,
  output logic [31:0]      issue_v1,
  output logic [31:0]      issue_v2,
  output logic [TAG_W-1:0] issue_tag
);

  localparam logic [OP_W-1:0] NOP = '1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] q;
    logic [31:0]      v;
  } opnd_t;

  // A pending operand grabs a matching broadcast; the ALU bus wins a tie.
  function automatic opnd_t snoop(input opnd_t            cur,
                                  input logic [TAG_W-1:0] a_num,
                                  input logic [31:0]      a_val,
                                  input logic [TAG_W-1:0] m_num,
                                  input logic [31:0]      m_val);
    opnd_t r;
    r = cur;
    if (cur.q != '0) begin
      if (cur.q == a_num) begin
        r.q = '0;
        r.v = a_val;
      end else if (cur.q == m_num) begin
        r.q = '0;
        r.v = m_val;
      end
    end
    return r;
  endfunction

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [OP_W-1:0]  op_d  [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  opnd_t            o1_q  [DEPTH];
  opnd_t            o1_d  [DEPTH];
  opnd_t            o2_q  [DEPTH];
  opnd_t            o2_d  [DEPTH];

  logic             iss_vld_q, iss_vld_d;
  logic [OP_W-1:0]  iss_op_q, iss_op_d;
  logic [31:0]      iss_v1_q, iss_v1_d;
  logic [31:0]      iss_v2_q, iss_v2_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;

  logic [CNT_W-1:0] count;
  logic             full;
  logic             iss_found, alloc_found;
  logic             issue_en, alloc_en;
  int               iss_idx, alloc_idx;

  always_comb begin
    count       = '0;
    iss_found   = 1'b0;
    iss_idx     = 0;
    alloc_found = 1'b0;
    alloc_idx   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(busy_q[i]);
      if (!iss_found && busy_q[i] && o1_q[i].q == '0 && o2_q[i].q == '0) begin
        iss_found = 1'b1;
        iss_idx   = i;
      end
      if (!alloc_found && !busy_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = i;
      end
    end
    full     = (count == CNT_W'(DEPTH));
    issue_en = iss_found && !alu_stall && !flush;
    alloc_en = in_valid && !full && !flush;

    iss_vld_d = 1'b0;
    iss_op_d  = NOP;
    iss_v1_d  = '0;
    iss_v2_d  = '0;
    iss_tag_d = '0;
    busy_d    = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]  = op_q[i];
      tag_d[i] = tag_q[i];
      o1_d[i]  = snoop(o1_q[i], alu_num, alu_value, mem_num, mem_value);
      o2_d[i]  = snoop(o2_q[i], alu_num, alu_value, mem_num, mem_value);
      if (issue_en && iss_idx == i) begin
        busy_d[i] = 1'b0;
        iss_vld_d = 1'b1;
        iss_op_d  = op_q[i];
        iss_v1_d  = o1_q[i].v;
        iss_v2_d  = o2_q[i].v;
        iss_tag_d = tag_q[i];
      end
      // Allocation only targets a free slot, so it never collides with the issuing one.
      if (alloc_en && alloc_idx == i) begin
        busy_d[i] = 1'b1;
        op_d[i]   = in_op;
        tag_d[i]  = in_tag;
        o1_d[i]   = snoop('{q: in_query1, v: in_value1}, alu_num, alu_value, mem_num, mem_value);
        o2_d[i]   = snoop('{q: in_query2, v: in_value2}, alu_num, alu_value, mem_num, mem_value);
      end
      if (flush) busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      iss_vld_q <= 1'b0;
      iss_op_q  <= NOP;
      iss_v1_q  <= '0;
      iss_v2_q  <= '0;
      iss_tag_q <= '0;
    end else begin
      busy_q    <= busy_d;
      iss_vld_q <= iss_vld_d;
      iss_op_q  <= iss_op_d;
      iss_v1_q  <= iss_v1_d;
      iss_v2_q  <= iss_v2_d;
      iss_tag_q <= iss_tag_d;
    end
  end

  // Entry payload is qualified by busy_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      op_q[i]  <= op_d[i];
      tag_q[i] <= tag_d[i];
      o1_q[i]  <= o1_d[i];
      o2_q[i]  <= o2_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(alloc_en && (&busy_q)));
  end

  assign rs_full     = full;
  assign issue_valid = iss_vld_q;
  assign issue_op    = iss_op_q;
  assign issue_v1    = iss_v1_q;
  assign issue_v2    = iss_v2_q;
  assign issue_tag   = iss_tag_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected issues are queued at dispatch
// and compared in order when the station presents them.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_op;
  logic [2:0]  in_tag;
  logic [31:0] in_value1;
  logic [2:0]  in_query1;
  logic [31:0] in_value2;
  logic [2:0]  in_query2;
  logic [2:0]  alu_num;
  logic [31:0] alu_value;
  logic [2:0]  mem_num;
  logic [31:0] mem_value;
  logic        alu_stall;
  logic        flush;
  logic        rs_full;
  logic        issue_valid;
  logic [4:0]  issue_op;
  logic [31:0] issue_v1;
  logic [31:0] issue_v2;
  logic [2:0]  issue_tag;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [2:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  reservation_station #(.DEPTH(4), .TAG_W(3), .OP_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_tag(in_tag),
    .in_value1(in_value1), .in_query1(in_query1), .in_value2(in_value2),
    .in_query2(in_query2), .alu_num(alu_num), .alu_value(alu_value),
    .mem_num(mem_num), .mem_value(mem_value), .alu_stall(alu_stall), .flush(flush),
    .rs_full(rs_full), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_tag(issue_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [4:0] op, input logic [2:0] tag,
                          input logic [31:0] v1, input logic [2:0] q1,
                          input logic [31:0] v2, input logic [2:0] q2);
    in_valid  = 1'b1;
    in_op     = op;
    in_tag    = tag;
    in_value1 = v1;
    in_query1 = q1;
    in_value2 = v2;
    in_query2 = q2;
  endtask

  task automatic expect_idle(input string name);
    chk({name, ".valid"}, 32'(issue_valid), 32'd0);
    chk({name, ".op"}, 32'(issue_op), 32'h1f);
  endtask

  task automatic expect_issue(input string name);
    exp_t e;
    chk({name, ".valid"}, 32'(issue_valid), 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb: observed issue with empty scoreboard, required none", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".op"}, 32'(issue_op), 32'(e.op));
      chk({name, ".v1"}, issue_v1, e.v1);
      chk({name, ".v2"}, issue_v2, e.v2);
      chk({name, ".tag"}, 32'(issue_tag), 32'(e.tag));
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_op = '0; in_tag = '0;
    in_value1 = '0; in_query1 = '0; in_value2 = '0; in_query2 = '0;
    alu_num = '0; alu_value = '0; mem_num = '0; mem_value = '0;
    alu_stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.full", 32'(rs_full), 32'd0);
    chk("rst.v1", issue_v1, 32'd0);
    chk("rst.tag", 32'(issue_tag), 32'd0);
    expect_idle("rst");

    // Ready-at-dispatch op issues one cycle later
    dispatch(5'h01, 3'd2, 32'd5, 3'd0, 32'd7, 3'd0);
    sb.push_back('{op: 5'h01, v1: 32'd5, v2: 32'd7, tag: 3'd2});
    step();
    in_valid = 1'b0;
    expect_idle("add.lat");
    step();
    expect_issue("add");

    // Wakeup from ALU broadcast
    dispatch(5'h02, 3'd3, 32'hdead, 3'd2, 32'd4, 3'd0);
    step();
    in_valid = 1'b0;
    expect_idle("sub.wait");
    sb.push_back('{op: 5'h02, v1: 32'd9, v2: 32'd4, tag: 3'd3});
    alu_num = 3'd2; alu_value = 32'd9;
    step();
    alu_num = 3'd0;
    expect_idle("sub.wake");
    step();
    expect_issue("sub");

    // Same-cycle forwarding at dispatch
    dispatch(5'h02, 3'd3, 32'hdead, 3'd2, 32'd4, 3'd0);
    alu_num = 3'd2; alu_value = 32'd9;
    sb.push_back('{op: 5'h02, v1: 32'd9, v2: 32'd4, tag: 3'd3});
    step();
    in_valid = 1'b0; alu_num = 3'd0;
    expect_idle("fwd.lat");
    step();
    expect_issue("fwd");
    step();
    expect_idle("fwd.after");

    // Fill all four entries waiting on tag 5
    for (int i = 0; i < 4; i++) begin
      dispatch(5'(3 + i), 3'(1 + i), 32'hbad0, 3'd5, 32'(i), 3'd0);
      sb.push_back('{op: 5'(3 + i), v1: 32'd1, v2: 32'(i), tag: 3'(1 + i)});
      step();
    end
    chk("fill.full", 32'(rs_full), 32'd1);
    dispatch(5'h0c, 3'd6, 32'd1, 3'd0, 32'd1, 3'd0);
    step();
    in_valid = 1'b0;
    chk("fill.drop_full", 32'(rs_full), 32'd1);
    expect_idle("fill.drop");
    mem_num = 3'd5; mem_value = 32'd1;
    step();
    mem_num = 3'd0;
    expect_idle("fill.wake");
    for (int i = 0; i < 4; i++) begin
      step();
      expect_issue($sformatf("drain%0d", i));
      if (i == 0) chk("drain.notfull", 32'(rs_full), 32'd0);
    end
    step();
    expect_idle("drain.after");

    // Both buses carry the same tag: ALU value wins
    dispatch(5'h07, 3'd6, 32'hdead, 3'd4, 32'd3, 3'd0);
    step();
    in_valid = 1'b0;
    alu_num = 3'd4; alu_value = 32'd10;
    mem_num = 3'd4; mem_value = 32'd20;
    sb.push_back('{op: 5'h07, v1: 32'd10, v2: 32'd3, tag: 3'd6});
    step();
    alu_num = 3'd0; mem_num = 3'd0;
    step();
    expect_issue("tie");

    // Second operand woken by the memory bus
    dispatch(5'h08, 3'd7, 32'd1, 3'd0, 32'hdead, 3'd3);
    step();
    in_valid = 1'b0;
    mem_num = 3'd3; mem_value = 32'h55;
    sb.push_back('{op: 5'h08, v1: 32'd1, v2: 32'h55, tag: 3'd7});
    step();
    mem_num = 3'd0;
    expect_idle("q2.wake");
    step();
    expect_issue("q2");

    // Two ready entries squashed by flush
    alu_stall = 1'b1;
    dispatch(5'h08, 3'd1, 32'd5, 3'd0, 32'd6, 3'd0);
    step();
    dispatch(5'h09, 3'd2, 32'd7, 3'd0, 32'd8, 3'd0);
    step();
    in_valid = 1'b0;
    expect_idle("stall.hold");
    flush = 1'b1; alu_stall = 1'b0;
    step();
    flush = 1'b0;
    chk("flush.full", 32'(rs_full), 32'd0);
    expect_idle("flush");
    step();
    expect_idle("flush.empty");

    // Two stall cycles delay issue by exactly two cycles
    dispatch(5'h0a, 3'd3, 32'd1, 3'd0, 32'd2, 3'd0);
    sb.push_back('{op: 5'h0a, v1: 32'd1, v2: 32'd2, tag: 3'd3});
    step();
    in_valid = 1'b0;
    alu_stall = 1'b1;
    step();
    expect_idle("stall1");
    step();
    expect_idle("stall2");
    alu_stall = 1'b0;
    step();
    expect_issue("stall.issue");
    step();
    expect_idle("stall.after");

    // Asynchronous reset with three waiting entries
    for (int i = 0; i < 3; i++) begin
      dispatch(5'h0b, 3'(1 + i), 32'd0, 3'd6, 32'd0, 3'd0);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst.full", 32'(rs_full), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.full", 32'(rs_full), 32'd0);
    step();
    rst = 1'b0;
    expect_idle("arst");
    alu_num = 3'd6; alu_value = 32'd3;
    step();
    alu_num = 3'd0;
    step();
    expect_idle("arst.cleared");
    step();
    expect_idle("arst.cleared2");

    chk("sb.drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
